// File: rtl/fifo_wr_arbiter.sv
// Four-requester write arbiter: grants one requester a burst of BURST_LEN nibbles into a FIFO.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin otherwise.
module fifo_wr_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int CW        = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [15:0] req_data,
   input  logic        fifo_prog_full,
   output logic [3:0]  grant,
   output logic [3:0]  ack,
   output logic [3:0]  fifo_din,
   output logic        fifo_din_en,
   output logic        busy,
   output logic        pad
);

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state, state_nxt;
   logic [3:0]    grant_nxt;
   logic [1:0]    owner, owner_nxt;
   logic [1:0]    last_winner, last_winner_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [3:0]    din_nxt;
   logic          en_nxt, pad_nxt;
   logic          found;
   logic [1:0]    winner;
   logic [3:0]    owner_nib;

   // Returns {found, index}; scanning from the lowest priority up lets the
   // last hit be the highest-priority requester.
   function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] lw);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
`ifdef FIFO_ARB_FIXED_PRIO_EN
      idx = lw;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) res = {1'b1, 2'(i)};
      end
`else
      for (int k = 4; k >= 1; k--) begin
         idx = lw + 2'(k);
         if (r[idx]) res = {1'b1, idx};
      end
`endif
      return res;
   endfunction

   assign {found, winner} = pick(req, last_winner);
   assign owner_nib = req_data[4*owner +: 4];
   assign busy      = (state == BURST);
   assign ack       = (state == BURST && !fifo_prog_full) ? grant : 4'h0;

   always_comb begin
      state_nxt       = state;
      grant_nxt       = grant;
      owner_nxt       = owner;
      last_winner_nxt = last_winner;
      cnt_nxt         = cnt;
      din_nxt         = fifo_din;
      en_nxt          = 1'b0;
      pad_nxt         = 1'b0;
      case (state)
         IDLE: begin
            if (found && !fifo_prog_full) begin
               state_nxt       = BURST;
               grant_nxt       = 4'b0001 << winner;
               owner_nxt       = winner;
               last_winner_nxt = winner;
               cnt_nxt         = '0;
            end
         end
         BURST: begin
            // A requester that has dropped req still gets its burst, padded with zeros.
            if (!fifo_prog_full) begin
               en_nxt  = 1'b1;
               din_nxt = req[owner] ? owner_nib : 4'h0;
               pad_nxt = !req[owner];
               cnt_nxt = cnt + CW'(1);
               if (cnt == CW'(BURST_LEN - 1)) begin
                  state_nxt = IDLE;
                  grant_nxt = 4'h0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= 4'h0;
         owner       <= 2'd0;
         last_winner <= 2'd3;
         cnt         <= '0;
         fifo_din    <= 4'h0;
         fifo_din_en <= 1'b0;
         pad         <= 1'b0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         owner       <= owner_nxt;
         last_winner <= last_winner_nxt;
         cnt         <= cnt_nxt;
         fifo_din    <= din_nxt;
         fifo_din_en <= en_nxt;
         pad         <= pad_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a per-cycle arbitration model predicts grants and
// queues expected FIFO writes; a negedge monitor pops and compares every write it sees.
module tb_fifo_wr_arbiter;
   localparam int BL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'h0;
   logic [15:0] req_data = 16'h0;
   logic        full = 1'b0;
   logic [3:0]  grant, ack, fifo_din;
   logic        fifo_din_en, busy, pad;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] nib;
      logic       pad;
   } wr_t;
   wr_t exp_q[$];

   // Reference model: who owns the port and how many beats they have written.
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_beats = 0;
   int m_last  = 3;

   logic [3:0] last_din = 4'h0;

   fifo_wr_arbiter #(.BURST_LEN(BL), .CW(3)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .fifo_prog_full(full), .grant(grant), .ack(ack), .fifo_din(fifo_din),
      .fifo_din_en(fifo_din_en), .busy(busy), .pad(pad)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int choose(input logic [3:0] r);
`ifdef FIFO_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
`endif
      return -1;
   endfunction

   // Drive one cycle of inputs, check the combinational/registered control, then
   // advance the model across the coming rising edge.
   task automatic step(input logic [3:0] r, input logic [15:0] d, input logic f);
      logic [3:0] eg;
      wr_t w;
      @(negedge clk);
      req = r; req_data = d; full = f;
      #1;
      eg = m_busy ? (4'b0001 << m_owner) : 4'h0;
      check("grant", grant, eg);
      check("ack", ack, (m_busy && !f) ? eg : 4'h0);
      check("busy", busy, m_busy);
      if (m_busy) begin
         if (!f) begin
            w.nib = r[m_owner] ? d[4*m_owner +: 4] : 4'h0;
            w.pad = !r[m_owner];
            exp_q.push_back(w);
            m_beats++;
            if (m_beats == BL) m_busy = 1'b0;
         end
      end else if (!f && r != 4'h0) begin
         m_owner = choose(r);
         m_last  = m_owner;
         m_busy  = 1'b1;
         m_beats = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      req = 4'h0; full = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_grant", grant, 4'h0);
      check("rst_ack", ack, 4'h0);
      check("rst_din", fifo_din, 4'h0);
      check("rst_en", fifo_din_en, 1'b0);
      check("rst_pad", pad, 1'b0);
      check("rst_busy", busy, 1'b0);
      exp_q.delete();
      m_busy = 1'b0; m_last = 3; m_beats = 0;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      wr_t w;
      if (rst) begin
         last_din = 4'h0;
      end else begin
         if (fifo_din_en) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write at %0t: got din=%0h none expected", $time, fifo_din);
            end else begin
               w = exp_q.pop_front();
               check("din", fifo_din, w.nib);
               check("pad", pad, w.pad);
            end
         end else begin
            check("din_hold", fifo_din, last_din);
            check("pad_idle", pad, 1'b0);
         end
         last_din = fifo_din;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Single requester, nibbles 1..4.
      step(4'b0001, 16'h0000, 1'b0);
      for (int i = 1; i <= 4; i++) step(4'b0001, 16'(i), 1'b0);
      step(4'b0000, 16'h0000, 1'b0);
      step(4'b0000, 16'h0000, 1'b0);

      // All requesting: rotation through four bursts.
      for (int i = 0; i < 22; i++) step(4'b1111, 16'($urandom), 1'b0);

      // Backpressure for 3 cycles after beat 2.
      do_reset();
      step(4'b0001, 16'h0000, 1'b0);
      step(4'b0001, 16'h0005, 1'b0);
      step(4'b0001, 16'h0006, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0001, 16'h000f, 1'b1);
      step(4'b0001, 16'h0007, 1'b0);
      step(4'b0001, 16'h0008, 1'b0);
      step(4'b0000, 16'h0000, 1'b0);

      // Requester 2 drops after beat 1; requester 3 is next.
      do_reset();
      step(4'b0100, 16'h0a00, 1'b0);
      step(4'b1100, 16'hba00, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1000, 16'hc000, 1'b0);
      for (int i = 0; i < 6; i++) step(4'b1000, 16'h1000 * (i + 1), 1'b0);

      // Reset during beat 3, then 0110 must go to requester 1.
      do_reset();
      step(4'b0001, 16'h0000, 1'b0);
      step(4'b0001, 16'h0003, 1'b0);
      step(4'b0001, 16'h0004, 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) step(4'b0110, 16'($urandom), 1'b0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         if (i % 200 == 150) do_reset();
         step(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 4) == 0));
      end

      for (int i = 0; i < BL + 4; i++) step(4'b0000, 16'h0000, 1'b0);
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4: nibbles written per grant; SHALL be a nonzero multiple of 4 so each grant fills whole 16-bit FIFO words.
REQ-002 Parameter CW, default 3: beat-counter width; SHALL satisfy 2^CW >= BURST_LEN.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  4  per-requester write request; bit i belongs to requester i.
REQ-006 req_data  in  16  requester nibbles; requester i drives bits [4i+3:4i].
REQ-007 fifo_prog_full  in  1  FIFO write-side almost-full backpressure.
REQ-008 grant  out  4  one-hot, registered; bit i high while requester i owns the write port.
REQ-009 ack  out  4  combinational per-beat acceptance; requester i advances its data on an edge where ack[i]=1.
REQ-010 fifo_din  out  4  registered nibble to the FIFO write port.
REQ-011 fifo_din_en  out  1  registered FIFO write enable.
REQ-012 busy  out  1  high in BURST state.
REQ-013 pad  out  1  registered; high with fifo_din_en when the written nibble is padding.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-015 In IDLE with any req bit high and fifo_prog_full=0, the block SHALL pick a winner, load grant one-hot, clear the beat counter and enter BURST on the next edge.
REQ-016 In IDLE with fifo_prog_full=1, the block SHALL issue no grant and remain in IDLE.
REQ-017 Winner selection SHALL be round-robin: search starts at index last_winner+1 modulo 4; last_winner updates when a grant is issued.
REQ-018 In BURST, ack[i] SHALL equal grant[i] AND NOT fifo_prog_full; ack SHALL be 0 in IDLE.
REQ-019 On each edge with an ack bit high, fifo_din SHALL load the granted nibble of req_data, fifo_din_en SHALL be 1, and the beat counter SHALL increment.
REQ-020 On an edge with no ack bit high, fifo_din_en SHALL be 0 and fifo_din SHALL hold its value.
REQ-021 While fifo_prog_full=1 in BURST, the FSM SHALL stay in BURST with the counter and grant held.
REQ-022 On the edge accepting beat BURST_LEN-1, the FSM SHALL enter IDLE and grant SHALL clear to 0.
REQ-023 The FSM SHALL spend at least one IDLE cycle between bursts.
REQ-024 Latency SHALL be: req high in cycle 0 (IDLE, not full) -> grant and ack in cycle 1 -> first fifo_din_en in cycle 2.
REQ-025 An unstalled BURST_LEN=4 burst SHALL have ack in cycles 1-4, fifo_din_en in cycles 2-5, and grant low in cycle 5.
REQ-026 If the granted requester drops req mid-burst, the burst SHALL continue to BURST_LEN beats; each beat accepted with req[i]=0 SHALL write 4'h0 with pad=1.
REQ-027 A requester raising req during another requester's burst SHALL NOT affect that burst.

Reset
REQ-028 While rst=1, the block SHALL force: state IDLE, grant=0, fifo_din=4'h0, fifo_din_en=0, pad=0, beat counter=0, last_winner=3, so requester 0 wins first.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately, with no further writes until a new grant.

Configuration
REQ-030 Macro FIFO_ARB_FIXED_PRIO_EN: when defined, winner selection SHALL be fixed priority (lowest index wins) and last_winner SHALL be unused.
REQ-031 Without FIFO_ARB_FIXED_PRIO_EN, round-robin selection per REQ-017 SHALL apply.

Verification
REQ-032 After reset, req=4'b0001, req_data nibble0 sequence 1,2,3,4, no full -> fifo_din 1,2,3,4 with fifo_din_en in cycles 2-5; grant=0001 in cycles 1-4.
REQ-033 req=4'b1111 held for 4 bursts -> grant order 0001, 0010, 0100, 1000; 16 writes total; 1 IDLE cycle between bursts.
REQ-034 fifo_prog_full=1 for 3 cycles after beat 2 of a burst -> ack and fifo_din_en low for those 3 cycles; burst still ends after exactly 4 writes.
REQ-035 Requester 2 drops req after beat 1 -> beats 2-4 write 4'h0 with pad=1; next grant goes to requester 3 if it is requesting.
REQ-036 rst pulsed during beat 3 -> all outputs zero within the reset cycle; req=4'b0110 afterwards -> first grant is 0010.
REQ-037 Build with FIFO_ARB_FIXED_PRIO_EN and req=4'b1010 held -> every grant is 0010; requester 3 never granted.
